// File: rtl/psum_deskew_acc.sv
// Deskews the three skewed column psums of the 3x3 array, accumulates each row across passes,
// and queues finished rows in an output FIFO. Define PSUM_ACC_SAT_EN for saturating accumulation.
module psum_deskew_acc #(
   parameter int int_bits  = 13,
   parameter int acc_bits  = 18,
   parameter int MAX_ROWS  = 8,
   parameter int OUT_DEPTH = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [3:0]          cfg_rows,
   input  logic [3:0]          cfg_passes,
   input  logic                in_valid,
   input  logic [int_bits-1:0] psum0,
   input  logic [int_bits-1:0] psum1,
   input  logic [int_bits-1:0] psum2,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [acc_bits-1:0] out0,
   output logic [acc_bits-1:0] out1,
   output logic [acc_bits-1:0] out2,
   output logic                busy,
   output logic                done,
   output logic                overflow_err
);

   localparam int RW = (MAX_ROWS > 1) ? $clog2(MAX_ROWS) : 1;
   localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FLUSH
   } state_t;

   typedef logic [2:0][acc_bits-1:0] vec_t;

   state_t               state_q, state_d;
   logic [RW-1:0]        rowCnt_q, rowCnt_d;
   logic [3:0]           passCnt_q, passCnt_d;
   logic [3:0]           rows_q, rows_d;
   logic [3:0]           passes_q, passes_d;
   logic [3:0]           rowsClamped;

   logic [int_bits-1:0]  p0Dly1_q, p0Dly2_q, p1Dly1_q;
   logic [1:0]           vldPipe_q;
   logic                 vecValid;
   vec_t                 vecIn;
   vec_t                 accVec;
   vec_t                 rowBuf_q [MAX_ROWS];

   logic                 rowLast, passLast, accept, fifoWr;

   vec_t                 fifoMem_q [OUT_DEPTH];
   logic [PW-1:0]        wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
   logic [CW-1:0]        count_q, count_d;
   logic                 ovf_q, ovf_d;
   logic                 fifoRd, fifoFull, fifoWrOk, fifoDrop, ovfClr;

   function automatic logic [acc_bits-1:0] accAdd(input logic [acc_bits-1:0] a,
                                                  input logic [acc_bits-1:0] b);
`ifdef PSUM_ACC_SAT_EN
      logic [acc_bits:0] s;
      s = {a[acc_bits-1], a} + {b[acc_bits-1], b};
      if (s[acc_bits] != s[acc_bits-1])
         return s[acc_bits] ? {1'b1, {(acc_bits-1){1'b0}}} : {1'b0, {(acc_bits-1){1'b1}}};
      return s[acc_bits-1:0];
`else
      return a + b;
`endif
   endfunction

   // Column c arrives c cycles late, so earlier columns are held back to line up with psum2.
   always_ff @(posedge clk) begin
      if (!reset) begin
         p0Dly1_q  <= '0;
         p0Dly2_q  <= '0;
         p1Dly1_q  <= '0;
         vldPipe_q <= '0;
      end else begin
         p0Dly1_q  <= psum0;
         p0Dly2_q  <= p0Dly1_q;
         p1Dly1_q  <= psum1;
         vldPipe_q <= {vldPipe_q[0], in_valid};
      end
   end

   assign vecValid = vldPipe_q[1];
   assign vecIn[0] = acc_bits'($signed(p0Dly2_q));
   assign vecIn[1] = acc_bits'($signed(p1Dly1_q));
   assign vecIn[2] = acc_bits'($signed(psum2));

   assign rowLast  = (4'(rowCnt_q) == rows_q - 4'd1);
   assign passLast = (passCnt_q == passes_q - 4'd1);
   assign accept   = (state_q == RUN) && vecValid;
   assign fifoWr   = accept && passLast;

   always_comb begin
      accVec = '0;
      for (int c = 0; c < 3; c++) begin
         if (passCnt_q == 4'd0)
            accVec[c] = vecIn[c];
         else
            accVec[c] = accAdd(rowBuf_q[rowCnt_q][c], vecIn[c]);
      end
   end

   // The final pass goes straight to the FIFO, so the buffer only needs updating before it.
   always_ff @(posedge clk) begin
      if (accept && !passLast)
         rowBuf_q[rowCnt_q] <= accVec;
   end

   always_comb begin
      if (cfg_rows == 4'd0)
         rowsClamped = 4'd1;
      else if (int'(cfg_rows) > MAX_ROWS)
         rowsClamped = 4'(MAX_ROWS);
      else
         rowsClamped = cfg_rows;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= IDLE;
         rowCnt_q  <= '0;
         passCnt_q <= '0;
         rows_q    <= '0;
         passes_q  <= '0;
      end else begin
         state_q   <= state_d;
         rowCnt_q  <= rowCnt_d;
         passCnt_q <= passCnt_d;
         rows_q    <= rows_d;
         passes_q  <= passes_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      rowCnt_d  = rowCnt_q;
      passCnt_d = passCnt_q;
      rows_d    = rows_q;
      passes_d  = passes_q;
      ovfClr    = 1'b0;
      done      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               rowCnt_d  = '0;
               passCnt_d = '0;
               rows_d    = rowsClamped;
               passes_d  = (cfg_passes == 4'd0) ? 4'd1 : cfg_passes;
               ovfClr    = 1'b1;
               state_d   = RUN;
            end
         end
         RUN: begin
            if (vecValid) begin
               if (rowLast) begin
                  rowCnt_d  = '0;
                  passCnt_d = passCnt_q + 4'd1;
                  if (passLast)
                     state_d = FLUSH;
               end else begin
                  rowCnt_d = rowCnt_q + RW'(1);
               end
            end
         end
         FLUSH: begin
            if (count_q == '0) begin
               done    = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy = (state_q != IDLE);

   // A full FIFO still takes a write when the head leaves in the same cycle.
   assign fifoRd   = out_valid & out_ready;
   assign fifoFull = (count_q == CW'(OUT_DEPTH));
   assign fifoWrOk = fifoWr & (~fifoFull | fifoRd);
   assign fifoDrop = fifoWr & fifoFull & ~fifoRd;

   always_comb begin
      wrPtr_d = fifoWrOk ? wrPtr_q + PW'(1) : wrPtr_q;
      rdPtr_d = fifoRd ? rdPtr_q + PW'(1) : rdPtr_q;
      count_d = count_q + CW'(fifoWrOk) - CW'(fifoRd);
      ovf_d   = ovf_q;
      if (ovfClr)
         ovf_d = 1'b0;
      else if (fifoDrop)
         ovf_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (fifoWrOk)
         fifoMem_q[wrPtr_q] <= accVec;
   end

   assign out_valid    = (count_q != '0);
   assign out0         = out_valid ? fifoMem_q[rdPtr_q][0] : '0;
   assign out1         = out_valid ? fifoMem_q[rdPtr_q][1] : '0;
   assign out2         = out_valid ? fifoMem_q[rdPtr_q][2] : '0;
   assign overflow_err = ovf_q;

endmodule
